// File: rtl/seg_disp_pkg.sv
// Shared definitions for the vending-machine price display.
// Contents: active-low 7-segment codes (bit7 = dp, bits 6:0 = g..a),
// converter state encoding, value index constants and a digit-to-segment
// lookup. Optional build macro SEG_LZ_BLANK_EN is consumed by the top.
package seg_disp_pkg;

    localparam int DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    // Decimal-point bit; clearing it lights the dp (active-low).
    localparam logic [7:0] DP_MASK   = 8'h80;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2
    } conv_state_e;

    localparam logic [1:0] IDX_NEED = 2'd0;
    localparam logic [1:0] IDX_PUT  = 2'd1;
    localparam logic [1:0] IDX_OUT  = 2'd2;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, 7-bit binary to 3 BCD nibbles.
// Ports: clk, rst_n (sync, active-low), start (latch bin, clear accumulator),
// bin[6:0], done (result valid, 8 cycles after start), hund/tens/ones.
module bin2bcd_seq
    import seg_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0]  sr_q, sr_d;
    logic [11:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [11:0] adj;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        dabble = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        sr_d   = sr_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        adj    = {dabble(acc_q[11:8]), dabble(acc_q[7:4]), dabble(acc_q[3:0])};
        if (start) begin
            sr_d   = bin;
            acc_d  = '0;
            cnt_d  = 3'd7;
            busy_d = 1'b1;
        end else if (busy_q && cnt_q != 3'd0) begin
            acc_d = {adj[10:0], sr_q[6]};
            sr_d  = {sr_q[5:0], 1'b0};
            cnt_d = cnt_q - 3'd1;
        end else if (busy_q) begin
            // result consumed during the done cycle
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done = busy_q && (cnt_q == 3'd0);
    assign hund = acc_q[11:8];
    assign tens = acc_q[7:4];
    assign ones = acc_q[3:0];

endmodule

// File: rtl/seg_price_display.sv
// Six-digit multiplexed price display (common anode, active-low).
// Ports: clk, rst_n (sync, active-low), price_need/price_put/price_out[6:0]
// in 0.1-yuan units; sel[5:0] digit select, seg[7:0] segments (bit7 = dp).
// Digit pairs [5:4]=need, [3:2]=put, [1:0]=out, each shown as X.Y.
// Values >= 100 show "--". Build macro SEG_LZ_BLANK_EN blanks a zero tens digit.
//
// state   | meaning
// S_LOAD  | start converter on the selected input (1 cycle)
// S_SHIFT | converter shifting, 7 cycles
// S_STORE | write tens/ones or overflow for the index, advance index
module seg_price_display
    import seg_disp_pkg::*;
#(
    parameter int SCAN_CNT_MAX = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] price_need,
    input  logic [6:0] price_put,
    input  logic [6:0] price_out,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int CW = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    conv_state_e state_q, state_d;
    logic [1:0]  vidx_q, vidx_d;
    logic [2:0]  shift_cnt_q, shift_cnt_d;
    logic [3:0]  tens_q [3];
    logic [3:0]  tens_d [3];
    logic [3:0]  ones_q [3];
    logic [3:0]  ones_d [3];
    logic [2:0]  ovf_q, ovf_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  didx_q, didx_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    logic       start;
    logic [6:0] bin;
    logic       done;
    logic [3:0] c_hund, c_tens, c_ones;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .done  (done),
        .hund  (c_hund),
        .tens  (c_tens),
        .ones  (c_ones)
    );

    always_comb begin
        case (vidx_q)
            IDX_NEED: bin = price_need;
            IDX_PUT:  bin = price_put;
            default:  bin = price_out;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        shift_cnt_d = shift_cnt_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        ovf_d       = ovf_q;
        start       = 1'b0;
        case (state_q)
            S_LOAD: begin
                start       = 1'b1;
                shift_cnt_d = 3'd6;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_cnt_q == 3'd0) state_d = S_STORE;
                else                     shift_cnt_d = shift_cnt_q - 3'd1;
            end
            S_STORE: begin
                if (done) begin
                    // tens and ones are written together so a pair never mixes
                    if (c_hund != 4'd0) begin
                        ovf_d[vidx_q] = 1'b1;
                    end else begin
                        ovf_d[vidx_q]  = 1'b0;
                        tens_d[vidx_q] = c_tens;
                        ones_d[vidx_q] = c_ones;
                    end
                end
                vidx_d  = (vidx_q == IDX_OUT) ? IDX_NEED : vidx_q + 2'd1;
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    logic [1:0] pair;
    logic [3:0] p_tens, p_ones;
    logic       p_ovf;

    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        didx_d     = didx_q;
        if (scan_cnt_q == CW'(SCAN_CNT_MAX - 1)) begin
            scan_cnt_d = '0;
            didx_d     = (didx_q == 3'(DIGITS - 1)) ? 3'd0 : didx_q + 3'd1;
        end

        // digits 5/4 -> need, 3/2 -> put, 1/0 -> out
        pair = 2'd2 - didx_q[2:1];
        case (pair)
            IDX_NEED: begin p_tens = tens_q[0]; p_ones = ones_q[0]; p_ovf = ovf_q[0]; end
            IDX_PUT:  begin p_tens = tens_q[1]; p_ones = ones_q[1]; p_ovf = ovf_q[1]; end
            default:  begin p_tens = tens_q[2]; p_ones = ones_q[2]; p_ovf = ovf_q[2]; end
        endcase

        sel_d = ~(6'b1 << didx_q);
        if (p_ovf) begin
            seg_d = SEG_DASH;
        end else if (didx_q[0]) begin
            seg_d = (LZ_BLANK && p_tens == 4'd0) ? SEG_BLANK : seg_code(p_tens);
            seg_d = seg_d & ~DP_MASK;
        end else begin
            seg_d = seg_code(p_ones);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            vidx_q      <= IDX_NEED;
            shift_cnt_q <= '0;
            tens_q      <= '{default: '0};
            ones_q      <= '{default: '0};
            ovf_q       <= '0;
            scan_cnt_q  <= '0;
            didx_q      <= '0;
            sel_q       <= 6'h3F;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            vidx_q      <= vidx_d;
            shift_cnt_q <= shift_cnt_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            ovf_q       <= ovf_d;
            scan_cnt_q  <= scan_cnt_d;
            didx_q      <= didx_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_price_display.sv
// Randomized self-checking bench for seg_price_display with SCAN_CNT_MAX=4.
// A cycle-indexed reference model tracks when each price is sampled and
// when its converted pair becomes visible, and predicts sel/seg every cycle.
module tb_seg_price_display;

    localparam int SCAN = 4;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] price_need = '0;
    logic [6:0] price_put = '0;
    logic [6:0] price_out = '0;
    logic [5:0] sel;
    logic [7:0] seg;

    int checks = 0;
    int failures = 0;

    seg_price_display #(.SCAN_CNT_MAX(SCAN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .price_need (price_need),
        .price_put  (price_put),
        .price_out  (price_out),
        .sel        (sel),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] code_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'h F8, 8'h80, 8'h90};

    function automatic logic [7:0] digit_seg(input int val, input bit is_tens);
        int t;
        if (val >= 100) return 8'hBF;
        if (is_tens) begin
            t = val / 10;
            if (LZ && t == 0) return 8'h7F;
            return code_tbl[t] & 8'h7F;
        end
        return code_tbl[val % 10];
    endfunction

    function automatic int input_of(input int v);
        if (v == 0) return int'(price_need);
        if (v == 1) return int'(price_put);
        return int'(price_out);
    endfunction

    int         j;          // cycles since the last reset edge
    int         pend [3];
    int         shown [3];
    int         md;
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    bit         model_ok = 1'b0;

    // Round of 27 cycles; value v is sampled in cycle 9v of the round and
    // becomes visible after cycle 9v+8. Outputs lag the scan index by one.
    always @(posedge clk) begin
        if (!rst_n) begin
            j        = 0;
            shown    = '{0, 0, 0};
            pend     = '{0, 0, 0};
            exp_sel  = 6'h3F;
            exp_seg  = 8'hFF;
            model_ok = 1'b1;
        end else if (model_ok) begin
            md      = (j / SCAN) % 6;
            exp_sel = ~(6'b1 << md);
            exp_seg = digit_seg(shown[2 - md / 2], (md % 2) == 1);
            for (int v = 0; v < 3; v++) begin
                if (j % 27 == 9 * v)     pend[v]  = input_of(v);
                if (j % 27 == 9 * v + 8) shown[v] = pend[v];
            end
            j++;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t sel=%h seg=%h expected sel=%h seg=%h",
                         $time, sel, seg, exp_sel, exp_seg);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp, input string name);
        logic [5:0] tgt;
        bit found;
        tgt = ~(6'b1 << d);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (sel === tgt) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout sel=%h expected=%h", name, sel, tgt);
        end else begin
            chk(name, seg, exp);
        end
    endtask

    logic [5:0] scan_tbl [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    initial begin
        rst_n = 1'b0;
        price_need = 7'd15;
        price_put  = 7'd5;
        price_out  = 7'd100;
        repeat (3) @(negedge clk);
        chk("rst_sel", {2'b00, sel}, 8'h3F);
        chk("rst_seg", seg, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_sel", {2'b00, sel}, 8'h3E);

        repeat (40) @(negedge clk);
        check_digit(5, 8'h79, "need_tens");
        check_digit(4, 8'h92, "need_ones");
        check_digit(3, LZ ? 8'h7F : 8'h40, "put_tens");
        check_digit(2, 8'h92, "put_ones");
        check_digit(1, 8'hBF, "out100_tens");
        check_digit(0, 8'hBF, "out100_ones");

        price_out = 7'd127;
        repeat (40) @(negedge clk);
        check_digit(1, 8'hBF, "out127_tens");
        check_digit(0, 8'hBF, "out127_ones");

        price_out = 7'd0;
        repeat (36) @(negedge clk);
        check_digit(1, LZ ? 8'h7F : 8'h40, "out0_tens");
        check_digit(0, 8'hC0, "out0_ones");

        // scan sequence from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            chk("scan_sel", {2'b00, sel}, {2'b00, scan_tbl[(k / SCAN) % 6]});
        end

        // reset pulse in the middle of the price_put conversion
        price_put = 7'd99;
        repeat (60) @(negedge clk);
        begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < 30 && !hit; n++) begin
                if (j % 27 == 12) hit = 1'b1;
                else @(negedge clk);
            end
            if (!hit) begin
                checks++;
                failures++;
                $display("FAIL midshift_align_timeout j=%0d expected phase=12", j);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sel", {2'b00, sel}, 8'h3F);
        chk("midrst_seg", seg, 8'hFF);
        rst_n = 1'b1;
        check_digit(3, LZ ? 8'h7F : 8'h40, "midrst_put_tens_cleared");
        repeat (36) @(negedge clk);
        check_digit(3, 8'h10, "put99_tens");
        check_digit(2, 8'h90, "put99_ones");

        // randomized traffic, with extra weight on the 99/100 boundary
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            case ($urandom_range(0, 3))
                0: price_need = 7'($urandom_range(0, 127));
                1: price_put  = 7'($urandom_range(0, 127));
                2: price_out  = 7'($urandom_range(0, 127));
                default: begin
                    price_need = 7'($urandom_range(98, 101));
                    price_put  = 7'($urandom_range(0, 9));
                    price_out  = 7'($urandom_range(0, 127));
                end
            endcase
        end
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout t=%0t expected=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
